// File: rtl/game_pkg.sv
// Shared game definitions: key enumeration, ASCII codes of the game keys,
// and the byte-to-key decode reused by the game state machine.
package game_pkg;

  localparam int unsigned KEY_W   = 4;
  localparam int unsigned ASCII_W = 8;

  typedef logic [KEY_W-1:0]   key_t;
  typedef logic [ASCII_W-1:0] ascii_t;

  localparam key_t KEY_NONE  = 4'd0;
  localparam key_t KEY_W_UP  = 4'd1;
  localparam key_t KEY_A     = 4'd2;
  localparam key_t KEY_S     = 4'd3;
  localparam key_t KEY_D     = 4'd4;
  localparam key_t KEY_J     = 4'd5;
  localparam key_t KEY_K     = 4'd6;
  localparam key_t KEY_L     = 4'd7;
  localparam key_t KEY_SPACE = 4'd8;

  localparam ascii_t ASC_W     = 8'h77;
  localparam ascii_t ASC_A     = 8'h61;
  localparam ascii_t ASC_S     = 8'h73;
  localparam ascii_t ASC_D     = 8'h64;
  localparam ascii_t ASC_J     = 8'h6A;
  localparam ascii_t ASC_K     = 8'h6B;
  localparam ascii_t ASC_L     = 8'h6C;
  localparam ascii_t ASC_SPACE = 8'h20;

  localparam ascii_t ASC_UPPER_FIRST = 8'h41;
  localparam ascii_t ASC_UPPER_LAST  = 8'h5A;
  localparam ascii_t ASC_CASE_BIT    = 8'h20;

  // Upper-case letters fold onto lower case when case-insensitive; unknown
  // bits fail every compare and fall through to KEY_NONE.
  function automatic key_t decode_key(input ascii_t b, input logic case_insensitive);
    ascii_t c;
    key_t   k;
    c = b;
    k = KEY_NONE;
    if (case_insensitive && (b >= ASC_UPPER_FIRST) && (b <= ASC_UPPER_LAST)) begin
      c = b | ASC_CASE_BIT;
    end
    case (c)
      ASC_W:     k = KEY_W_UP;
      ASC_A:     k = KEY_A;
      ASC_S:     k = KEY_S;
      ASC_D:     k = KEY_D;
      ASC_J:     k = KEY_J;
      ASC_K:     k = KEY_K;
      ASC_L:     k = KEY_L;
      ASC_SPACE: k = KEY_SPACE;
      default:   k = KEY_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/key_converter.sv
// Keyboard ASCII byte to game key code, registered once; pure level
// translation with no debouncing or edge detection.
module key_converter
  import game_pkg::*;
#(
  parameter int unsigned CASE_INSENSITIVE = 1
) (
  output logic [KEY_W-1:0]   key,
  input  logic [ASCII_W-1:0] keyboard,
  input  logic               clk,
  input  logic               rst
);

  localparam logic CI = 1'(CASE_INSENSITIVE != 0);

  key_t key_d;
  key_t key_q;

  always_comb begin
    key_d = KEY_NONE;
    key_d = decode_key(keyboard, CI);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= KEY_NONE;
    end else begin
      key_q <= key_d;
    end
  end

  assign key = key_q;

endmodule

// File: tb/tb_key_converter.sv
// Bench for key_converter: case-insensitive and case-sensitive builds driven
// from the same keyboard byte, checked against a lookup-string model.
`timescale 1ns/1ps
module tb_key_converter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] keyboard;
  logic [3:0] key_ci;
  logic [3:0] key_cs;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  key_converter #(.CASE_INSENSITIVE(1)) dut_ci (
    .key(key_ci), .keyboard(keyboard), .clk(clk), .rst(rst)
  );

  key_converter #(.CASE_INSENSITIVE(0)) dut_cs (
    .key(key_cs), .keyboard(keyboard), .clk(clk), .rst(rst)
  );

  typedef struct {
    logic [7:0] kb;
    int         exp_ci;
    int         exp_cs;
  } vec_t;

  vec_t tbl[$];

  // Key code is 1 + position in "wasdjkl "; letters also match upper case.
  function automatic int ref_key(input logic [7:0] b, input bit ci);
    string keys;
    keys = "wasdjkl ";
    for (int i = 0; i < 8; i++) begin
      if (b == 8'(keys[i])) return i + 1;
      if (ci && i < 7 && b == 8'(keys[i]) - 8'h20) return i + 1;
    end
    return 0;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input int exp);
    n_vec++;
    if (act !== 4'(exp)) begin
      n_bad++;
      $display("FAIL %s: key=%0d expected=%0d (keyboard=%h)", name, act, exp, keyboard);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] keyset[15];
    keyset = '{8'h77, 8'h61, 8'h73, 8'h64, 8'h6A, 8'h6B, 8'h6C, 8'h20,
               8'h57, 8'h41, 8'h53, 8'h44, 8'h4A, 8'h4B, 8'h4C};

    // Reset holds key at zero even with a valid key byte present.
    rst = 1'b1;
    keyboard = 8'h77;
    #1;
    check("reset_t0_ci", key_ci, 0);
    check("reset_t0_cs", key_cs, 0);
    step();
    step();
    check("reset_held_ci", key_ci, 0);
    check("reset_held_cs", key_cs, 0);
    rst = 1'b0;
    step();
    check("release_ci", key_ci, 1);
    check("release_cs", key_cs, 1);

    // Decode table, applied back to back.
    for (int i = 0; i < 8; i++) tbl.push_back('{keyset[i], i + 1, i + 1});
    for (int i = 0; i < 7; i++) tbl.push_back('{keyset[8 + i], i + 1, 0});
    tbl.push_back('{8'h00, 0, 0});
    tbl.push_back('{8'h78, 0, 0});
    tbl.push_back('{8'h31, 0, 0});
    tbl.push_back('{8'hF7, 0, 0});
    tbl.push_back('{8'h0D, 0, 0});
    tbl.push_back('{8'hE1, 0, 0});
    tbl.push_back('{8'h40, 0, 0});
    tbl.push_back('{8'h5B, 0, 0});
    tbl.push_back('{8'h57, 1, 0});
    tbl.push_back('{8'h77, 1, 1});
    tbl.push_back('{8'h20, 8, 8});
    foreach (tbl[i]) begin
      keyboard = tbl[i].kb;
      step();
      check("table_ci", key_ci, tbl[i].exp_ci);
      check("table_cs", key_cs, tbl[i].exp_cs);
    end

    // Level behaviour: held byte repeats, change lands exactly one edge later.
    keyboard = 8'h61;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_a", key_ci, 2);
    end
    keyboard = 8'h64;
    #1;
    check("hold_before_edge", key_ci, 2);
    step();
    check("hold_then_d", key_ci, 4);

    // Asynchronous reset between edges.
    keyboard = 8'h20;
    step();
    check("pre_reset_space", key_ci, 8);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_reset_ci", key_ci, 0);
    check("async_reset_cs", key_cs, 0);
    keyboard = 8'h77;
    step();
    check("reset_ignores_kb", key_ci, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("resume_ci", key_ci, 1);
    check("resume_cs", key_cs, 1);

    // Unknown byte decodes to NONE.
    keyboard = 8'hxx;
    step();
    check("x_byte_ci", key_ci, $isunknown(keyboard) ? 0 : ref_key(keyboard, 1'b1));
    check("x_byte_cs", key_cs, $isunknown(keyboard) ? 0 : ref_key(keyboard, 1'b0));

    // Random bytes, biased toward the key set.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) keyboard = keyset[$urandom_range(0, 14)];
      else keyboard = 8'($urandom_range(0, 255));
      step();
      check("rand_ci", key_ci, ref_key(keyboard, 1'b1));
      check("rand_cs", key_cs, ref_key(keyboard, 1'b0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
